// File: rtl/lc3_pkg.sv
// LC-3 controller shared definitions: opcodes, state encoding, datapath mux encodings.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_RTI  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RES  = 4'hD;
    localparam logic [3:0] OP_LEA  = 4'hE;
    localparam logic [3:0] OP_TRAP = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_IND,
        ST_MEM,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_LEA,
        CLS_BR,
        CLS_JMP,
        CLS_JSR,
        CLS_LOAD,
        CLS_STORE,
        CLS_TRAP,
        CLS_ILL
    } op_class_t;

    localparam logic [1:0] MA_PC   = 2'd0;
    localparam logic [1:0] MA_EA   = 2'd1;
    localparam logic [1:0] MA_MDR  = 2'd2;
    localparam logic [1:0] MA_TRAP = 2'd3;

    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_OFF  = 2'd1;
    localparam logic [1:0] PC_BASE = 2'd2;
    localparam logic [1:0] PC_MEM  = 2'd3;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_EA   = 2'd2;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_AND  = 2'd1;
    localparam logic [1:0] ALU_NOT  = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;

    localparam logic [7:0] HALT_VEC = 8'h25;

    typedef struct packed {
        op_class_t  cls;
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic [2:0] dr;
        logic [1:0] alu_op;
        logic       ind;
        logic       store;
    } dec_t;

    function automatic logic is_halt_trap(input logic [15:0] instr);
        return instr[7:0] == HALT_VEC;
    endfunction

endpackage

// File: rtl/lc3_decode.sv
// Instruction field decoder: opcode class, register addresses, ALU op, indirect/store flags.
// Latency: combinational.
// Backpressure: none; pure function of ir.
module lc3_decode
    import lc3_pkg::*;
(
    input  logic [15:0] ir,
    output dec_t        dec
);

    always_comb begin
        dec.cls    = CLS_ILL;
        dec.sr1    = ir[8:6];
        dec.sr2    = ir[2:0];
        dec.dr     = ir[11:9];
        dec.alu_op = ALU_PASS;
        dec.ind    = 1'b0;
        dec.store  = 1'b0;
        case (ir[15:12])
            OP_ADD: begin
                dec.cls    = CLS_ALU;
                dec.alu_op = ALU_ADD;
            end
            OP_AND: begin
                dec.cls    = CLS_ALU;
                dec.alu_op = ALU_AND;
            end
            OP_NOT: begin
                dec.cls    = CLS_ALU;
                dec.alu_op = ALU_NOT;
            end
            OP_LEA: dec.cls = CLS_LEA;
            OP_BR:  dec.cls = CLS_BR;
            OP_JMP: dec.cls = CLS_JMP;
            OP_JSR: begin
                dec.cls = CLS_JSR;
                dec.dr  = 3'd7;
            end
            OP_LD, OP_LDR: dec.cls = CLS_LOAD;
            OP_LDI: begin
                dec.cls = CLS_LOAD;
                dec.ind = 1'b1;
            end
            // Stores read the source data register through the second port.
            OP_ST, OP_STR: begin
                dec.cls   = CLS_STORE;
                dec.store = 1'b1;
                dec.sr2   = ir[11:9];
            end
            OP_STI: begin
                dec.cls   = CLS_STORE;
                dec.store = 1'b1;
                dec.ind   = 1'b1;
                dec.sr2   = ir[11:9];
            end
            OP_TRAP: begin
                dec.cls = CLS_TRAP;
                dec.dr  = 3'd7;
            end
            default: dec.cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/lc3_control_fsm.sv
// Multi-cycle LC-3 sequencer (FETCH/DECODE/EXEC/IND/MEM/HALT); LC3_CTRL_TRAP_EN enables TRAP vectoring.
// Latency: 3 cycles ALU/LEA/BR/JMP/JSR, 4 LD/ST/LDR/STR, 5 LDI/STI, +1 per memory wait cycle.
// Backpressure: mem_req/mem_we/mem_addr_sel held until mem_ready; mem_ready without mem_req ignored.
module lc3_control_fsm
    import lc3_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h3000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_addr_sel,
    output logic        pc_load,
    output logic [1:0]  pc_sel,
    output logic [15:0] pc_init,
    output logic [15:0] ir,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [2:0]  dr,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_op,
    output logic        halted,
    output logic        illegal
);

    state_t      state_q, state_d;
    logic [15:0] ir_q;
    logic        run_q;
    logic        halted_q;
    logic        illegal_q;
    logic        ir_load;
    logic        set_illegal;
    logic        ack;
    dec_t        dec;

    lc3_decode u_decode (
        .ir  (ir_q),
        .dec (dec)
    );

    assign pc_init = RESET_PC;
    assign ir      = ir_q;
    assign sr1     = dec.sr1;
    assign sr2     = dec.sr2;
    assign dr      = dec.dr;
    assign halted  = halted_q;
    assign illegal = illegal_q;

    // run_q is cleared by reset, so requests vanish the instant rst rises
    // and only reappear after the first clock edge out of reset.
    assign ack = run_q && mem_ready;

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = MA_PC;
        pc_load      = 1'b0;
        pc_sel       = PC_INC;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        alu_op       = ALU_ADD;
        ir_load      = 1'b0;
        set_illegal  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = run_q;
                if (ack) begin
                    ir_load = 1'b1;
                    pc_load = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (dec.cls)
                    CLS_ALU: begin
                        reg_write = 1'b1;
                        alu_op    = dec.alu_op;
                    end
                    CLS_LEA: begin
                        reg_write = 1'b1;
                        wb_sel    = WB_EA;
                    end
                    CLS_BR: begin
                        pc_sel  = PC_OFF;
                        pc_load = br_taken;
                    end
                    CLS_JMP: begin
                        pc_sel  = PC_BASE;
                        pc_load = 1'b1;
                    end
                    // Link write lands on the negedge, before the PC update at the next posedge.
                    CLS_JSR: begin
                        reg_write = 1'b1;
                        alu_op    = ALU_PASS;
                        pc_load   = 1'b1;
                        pc_sel    = ir_q[11] ? PC_OFF : PC_BASE;
                    end
                    CLS_LOAD, CLS_STORE: state_d = dec.ind ? ST_IND : ST_MEM;
                    CLS_TRAP: begin
`ifdef LC3_CTRL_TRAP_EN
                        if (is_halt_trap(ir_q)) begin
                            state_d = ST_HALT;
                        end else begin
                            reg_write = 1'b1;
                            alu_op    = ALU_PASS;
                            state_d   = ST_MEM;
                        end
`else
                        state_d = ST_HALT;
`endif
                    end
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = ST_HALT;
                    end
                endcase
            end
            ST_IND: begin
                mem_req      = run_q;
                mem_addr_sel = MA_EA;
                if (ack) state_d = ST_MEM;
            end
            ST_MEM: begin
                mem_req = run_q;
                if (dec.cls == CLS_TRAP) begin
                    mem_addr_sel = MA_TRAP;
                    pc_sel       = PC_MEM;
                    if (ack) begin
                        pc_load = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else begin
                    mem_addr_sel = dec.ind ? MA_MDR : MA_EA;
                    mem_we       = dec.store;
                    if (!dec.store) wb_sel = WB_MEM;
                    if (ack) begin
                        reg_write = !dec.store;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            ir_q      <= 16'h0000;
            run_q     <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (ir_load)              ir_q      <= mem_rdata;
            if (set_illegal)          illegal_q <= 1'b1;
            if (state_d == ST_HALT)   halted_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed cycle-by-cycle checks of the LC-3 sequencer against hand-computed control values.
module tb_lc3_control_fsm;

    logic        clk;
    logic        rst;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        br_taken;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_addr_sel;
    logic        pc_load;
    logic [1:0]  pc_sel;
    logic [15:0] pc_init;
    logic [15:0] ir;
    logic [2:0]  sr1, sr2, dr;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [1:0]  alu_op;
    logic        halted;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    lc3_control_fsm #(.RESET_PC(16'h3000)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .br_taken     (br_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .pc_load      (pc_load),
        .pc_sel       (pc_sel),
        .pc_init      (pc_init),
        .ir           (ir),
        .sr1          (sr1),
        .sr2          (sr2),
        .dr           (dr),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .alu_op       (alu_op),
        .halted       (halted),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs applied just after the edge, outputs sampled after settling.
    task automatic cyc(input logic rdy, input logic [15:0] rd, input logic tk);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        mem_rdata = rd;
        br_taken  = tk;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
        br_taken  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Fetch with zero wait, then decode; returns sampling the EXEC cycle (cycle 3).
    task automatic run_to_exec(input logic [15:0] instr, input logic tk);
        do_reset();
        cyc(1'b1, instr, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 16'h0000, tk);
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
        br_taken  = 1'b0;
        repeat (2) @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc_load", pc_load, 0);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_addr_sel", mem_addr_sel, 0);
        chk("rst_pc_init", pc_init, 16'h3000);

        // ADD R1,R1,#2
        do_reset();
        cyc(1'b1, 16'h1262, 1'b0);
        chk("add_c1_req", mem_req, 1);
        chk("add_c1_we", mem_we, 0);
        chk("add_c1_pc_load", pc_load, 1);
        chk("add_c1_pc_sel", pc_sel, 0);
        cyc(1'b1, 16'hFFFF, 1'b0);
        chk("add_c2_req", mem_req, 0);
        chk("add_c2_ir", ir, 16'h1262);
        chk("add_c2_reg_write", reg_write, 0);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("add_c3_reg_write", reg_write, 1);
        chk("add_c3_dr", dr, 1);
        chk("add_c3_sr1", sr1, 1);
        chk("add_c3_sr2", sr2, 2);
        chk("add_c3_wb_sel", wb_sel, 0);
        chk("add_c3_alu_op", alu_op, 0);
        chk("add_c3_ir_stray", ir, 16'h1262);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("add_c4_req", mem_req, 1);
        chk("add_c4_addr_sel", mem_addr_sel, 0);
        chk("add_c4_reg_write", reg_write, 0);

        // BRz taken / not taken
        run_to_exec(16'h0405, 1'b1);
        chk("brt_pc_load", pc_load, 1);
        chk("brt_pc_sel", pc_sel, 1);
        chk("brt_reg_write", reg_write, 0);
        chk("brt_dr_mask", dr, 2);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("brt_c4_req", mem_req, 1);
        run_to_exec(16'h0405, 1'b0);
        chk("brn_pc_load", pc_load, 0);

        // JMP R7, JSR, JSRR R2, LEA R1
        run_to_exec(16'hC1C0, 1'b0);
        chk("jmp_pc_load", pc_load, 1);
        chk("jmp_pc_sel", pc_sel, 2);
        chk("jmp_sr1", sr1, 7);
        chk("jmp_reg_write", reg_write, 0);
        run_to_exec(16'h4802, 1'b0);
        chk("jsr_reg_write", reg_write, 1);
        chk("jsr_dr", dr, 7);
        chk("jsr_pc_load", pc_load, 1);
        chk("jsr_pc_sel", pc_sel, 1);
        run_to_exec(16'h4080, 1'b0);
        chk("jsrr_pc_sel", pc_sel, 2);
        chk("jsrr_sr1", sr1, 2);
        chk("jsrr_dr", dr, 7);
        run_to_exec(16'hE3FF, 1'b0);
        chk("lea_reg_write", reg_write, 1);
        chk("lea_wb_sel", wb_sel, 2);
        chk("lea_dr", dr, 1);

        // LDI R2 with two wait cycles on the pointer and data reads: 9 cycles total
        run_to_exec(16'hA401, 1'b0);
        chk("ldi_c3_req", mem_req, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(i == 2, 16'h4000, 1'b0);
            chk($sformatf("ldi_ind%0d_req", i), mem_req, 1);
            chk($sformatf("ldi_ind%0d_sel", i), mem_addr_sel, 1);
            chk($sformatf("ldi_ind%0d_we", i), mem_we, 0);
            chk($sformatf("ldi_ind%0d_rw", i), reg_write, 0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(i == 2, 16'h1234, 1'b0);
            chk($sformatf("ldi_mem%0d_req", i), mem_req, 1);
            chk($sformatf("ldi_mem%0d_sel", i), mem_addr_sel, 2);
            chk($sformatf("ldi_mem%0d_rw", i), reg_write, (i == 2) ? 16'd1 : 16'd0);
        end
        chk("ldi_wb_sel", wb_sel, 1);
        chk("ldi_dr", dr, 2);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("ldi_c10_req", mem_req, 1);
        chk("ldi_c10_sel", mem_addr_sel, 0);

        // STR R2,R1,#2
        do_reset();
        cyc(1'b1, 16'h7442, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("str_sr2", sr2, 2);
        chk("str_sr1", sr1, 1);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("str_c3_rw", reg_write, 0);
        cyc(1'b1, 16'h0000, 1'b0);
        chk("str_c4_req", mem_req, 1);
        chk("str_c4_we", mem_we, 1);
        chk("str_c4_sel", mem_addr_sel, 1);
        chk("str_c4_rw", reg_write, 0);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("str_c5_we", mem_we, 0);
        chk("str_c5_req", mem_req, 1);

        // Reserved opcode and RTI halt with illegal set
        run_to_exec(16'hD000, 1'b0);
        chk("res_c3_illegal", illegal, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'h1262, 1'b0);
            chk($sformatf("res_halt%0d_req", i), mem_req, 0);
            chk($sformatf("res_halt%0d_halted", i), halted, 1);
            chk($sformatf("res_halt%0d_illegal", i), illegal, 1);
        end
        run_to_exec(16'h8000, 1'b0);
        cyc(1'b1, 16'h1262, 1'b0);
        chk("rti_illegal", illegal, 1);
        chk("rti_halted", halted, 1);

        // TRAP x25 halts cleanly in either build
        run_to_exec(16'hF025, 1'b0);
        chk("halt25_c3_rw", reg_write, 0);
        cyc(1'b1, 16'h1262, 1'b0);
        chk("halt25_halted", halted, 1);
        chk("halt25_illegal", illegal, 0);
        chk("halt25_req", mem_req, 0);

        // TRAP x20
        run_to_exec(16'hF020, 1'b0);
`ifdef LC3_CTRL_TRAP_EN
        chk("trap_c3_rw", reg_write, 1);
        chk("trap_c3_dr", dr, 7);
        cyc(1'b1, 16'h0400, 1'b0);
        chk("trap_c4_req", mem_req, 1);
        chk("trap_c4_sel", mem_addr_sel, 3);
        chk("trap_c4_we", mem_we, 0);
        chk("trap_c4_pc_load", pc_load, 1);
        chk("trap_c4_pc_sel", pc_sel, 3);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("trap_c5_sel", mem_addr_sel, 0);
        chk("trap_c5_halted", halted, 0);
`else
        chk("trap_c3_rw", reg_write, 0);
        cyc(1'b1, 16'h0400, 1'b0);
        chk("trap_c4_req", mem_req, 0);
        chk("trap_c4_halted", halted, 1);
        chk("trap_c4_illegal", illegal, 0);
`endif

        // Reset during a stalled fetch
        run_to_exec(16'h1262, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0);
        chk("mid_pre_req", mem_req, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_req_drop", mem_req, 0);
        chk("mid_ir", ir, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 16'h0000, 1'b0);
        chk("mid_restart_req", mem_req, 1);
        chk("mid_restart_sel", mem_addr_sel, 0);
        chk("mid_restart_ir", ir, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
